// File: rtl/ghr_pkg.sv
// Shared types and defaults for the global-history checkpoint controller.
package ghr_pkg;

  localparam int DEFAULT_HISTORY_WIDTH = 8;
  localparam int DEFAULT_CKPT_DEPTH    = 4;

  // Checkpoint layout for the default history width; the controller builds
  // the same layout at its own parameterized width.
  typedef struct packed {
    logic [DEFAULT_HISTORY_WIDTH-1:0] ghr_before;
    logic                             pred_taken;
  } ghr_ckpt_t;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } ghr_state_e;

endpackage

// File: rtl/ghr_ckpt_ctrl_if.sv
// Fetch/execute side bundle of the history checkpoint controller.
interface ghr_ckpt_ctrl_if #(
  parameter int HISTORY_WIDTH = 8,
  parameter int CKPT_DEPTH    = 4
);
  localparam int CNT_WIDTH = $clog2(CKPT_DEPTH) + 1;

  logic                     pred_valid_i;
  logic                     pred_taken_i;
  logic                     pred_ready_o;
  logic                     resolve_valid_i;
  logic                     resolve_taken_i;
  logic                     flush_i;
  logic [HISTORY_WIDTH-1:0] spec_ghr_o;
  logic [HISTORY_WIDTH-1:0] commit_ghr_o;
  logic                     mispredict_o;
  logic [CNT_WIDTH-1:0]     inflight_o;
  logic                     err_o;

  // Pipeline side: fetch and branch unit drive predictions and resolves.
  modport master (
    output pred_valid_i, pred_taken_i, resolve_valid_i, resolve_taken_i, flush_i,
    input  pred_ready_o, spec_ghr_o, commit_ghr_o, mispredict_o, inflight_o, err_o
  );

  // Controller side.
  modport slave (
    input  pred_valid_i, pred_taken_i, resolve_valid_i, resolve_taken_i, flush_i,
    output pred_ready_o, spec_ghr_o, commit_ghr_o, mispredict_o, inflight_o, err_o
  );

endinterface

// File: rtl/ghr_ckpt_fifo.sv
// In-order checkpoint FIFO with clear; count kept separately so full/empty never alias.
module ghr_ckpt_fifo
  import ghr_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = ghr_ckpt_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  input  logic                   clear,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign do_push = push && (count != FULL_CNT);
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // Pointers and occupancy; clear wins over any same-cycle push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + (PW + 1)'(1);
      else if (!do_push && do_pop) count <= count - (PW + 1)'(1);
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ghr_ckpt_ctrl.sv
// Speculative/architectural global history with per-branch checkpoints and recovery.
module ghr_ckpt_ctrl
  import ghr_pkg::*;
#(
  parameter int HISTORY_WIDTH = DEFAULT_HISTORY_WIDTH,
  parameter int CKPT_DEPTH    = DEFAULT_CKPT_DEPTH
) (
  input logic           clk_i,
  input logic           rst_ni,
  ghr_ckpt_ctrl_if.slave bus
);

  localparam int CW = $clog2(CKPT_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(CKPT_DEPTH);

  typedef struct packed {
    logic [HISTORY_WIDTH-1:0] ghr_before;
    logic                     pred_taken;
  } ckpt_t;

  ghr_state_e               state;
  ghr_state_e               state_next;
  logic [HISTORY_WIDTH-1:0] spec_q;
  logic [HISTORY_WIDTH-1:0] spec_next;
  logic [HISTORY_WIDTH-1:0] commit_q;
  logic [HISTORY_WIDTH-1:0] commit_next;
  logic [HISTORY_WIDTH-1:0] restore_ghr;
  logic                     mis_q;
  logic                     err_q;
  logic                     ready;
  logic                     accept;
  logic                     pop;
  logic                     mis;
  logic                     clear;
  ckpt_t                    head;
  ckpt_t                    push_entry;
  logic [CW-1:0]            count;

  assign accept      = bus.pred_valid_i && ready;
  assign pop         = bus.resolve_valid_i && (count != '0);
  assign mis         = pop && (head.pred_taken != bus.resolve_taken_i);
  assign clear       = bus.flush_i || mis;
  assign push_entry  = '{ghr_before: spec_q, pred_taken: bus.pred_taken_i};
  assign restore_ghr = (head.ghr_before << 1) | {{(HISTORY_WIDTH-1){1'b0}}, bus.resolve_taken_i};

  ghr_ckpt_fifo #(
    .DEPTH   (CKPT_DEPTH),
    .entry_t (ckpt_t)
  ) u_fifo (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .push      (accept),
    .push_data (push_entry),
    .pop       (pop),
    .clear     (clear),
    .head      (head),
    .count     (count)
  );

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= RUN;
    else         state <= state_next;
  end

  // Enter RECOVER on a mispredict or flush; leave it after exactly one cycle.
  always_comb begin
    state_next = state;
    unique case (state)
      RUN:     if (clear) state_next = RECOVER;
      RECOVER: state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // FSM outputs: stall fetch while recovering or full; mispredict marks the recovery cycle.
  always_comb begin
    ready            = (state == RUN) && (count < DEPTH_CNT);
    bus.pred_ready_o = ready;
    bus.mispredict_o = (state == RECOVER) && mis_q;
  end

  // Next history values; flush restores to the committed history after this cycle's resolve.
  always_comb begin
    commit_next = commit_q;
    if (pop) commit_next = {commit_q[HISTORY_WIDTH-2:0], bus.resolve_taken_i};
    spec_next = spec_q;
    if (bus.flush_i)  spec_next = commit_next;
    else if (mis)     spec_next = restore_ghr;
    else if (accept)  spec_next = {spec_q[HISTORY_WIDTH-2:0], bus.pred_taken_i};
  end

  // History registers, mispredict flag and sticky empty-resolve error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      spec_q   <= '0;
      commit_q <= '0;
      mis_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      spec_q   <= spec_next;
      commit_q <= commit_next;
      mis_q    <= mis;
      if (bus.resolve_valid_i && (count == '0)) err_q <= 1'b1;
    end
  end

  assign bus.spec_ghr_o   = spec_q;
  assign bus.commit_ghr_o = commit_q;
  assign bus.inflight_o   = count;
  assign bus.err_o        = err_q;

endmodule
